// File: rtl/fib_req_arbiter.sv
// Two-port round-robin arbiter in front of a shared Fibonacci engine.
// The datapath advances two terms per cycle and returns F(n) mod 2^W with a sticky overflow flag.
module fib_req_arbiter #(
    parameter int W    = 16,
    parameter int IDXW = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [IDXW-1:0] req0_index,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [IDXW-1:0] req1_index,
    output logic            req1_ready,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic [W-1:0]    rsp_value,
    output logic            rsp_ovf,
    output logic            busy
);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t            state_q;
    logic [W-1:0]      a_q, b_q;
    logic              a_ovf_q, b_ovf_q;
    logic [IDXW-2:0]   steps_q;
    logic              odd_q, id_q, last_q;
    logic              rsp_valid_q, rsp_id_q, rsp_ovf_q;
    logic [W-1:0]      rsp_value_q;

    logic [W+1:0]      sum_ab, sum_a2b;
    logic [W-1:0]      a_d, b_d;
    logic              a_ovf_d, b_ovf_d;
    logic              gnt0, gnt1, hs, hs_port;
    logic [IDXW-1:0]   hs_index;

    // On a tie the port that was not served last wins.
    always_comb begin
        gnt0       = req0_valid & (~req1_valid | last_q);
        gnt1       = req1_valid & (~req0_valid | ~last_q);
        req0_ready = (state_q == IDLE) & ~rst & gnt0;
        req1_ready = (state_q == IDLE) & ~rst & gnt1;
        hs         = req0_ready | req1_ready;
        hs_port    = req1_ready;
        hs_index   = req1_ready ? req1_index : req0_index;
    end

    // (F(k), F(k+1)) -> (F(k+2), F(k+3)); carries from the widened sums feed the sticky flags.
    always_comb begin
        sum_ab  = {2'b00, a_q} + {2'b00, b_q};
        sum_a2b = {2'b00, a_q} + {1'b0, b_q, 1'b0};
        a_d     = sum_ab[W-1:0];
        b_d     = sum_a2b[W-1:0];
        a_ovf_d = a_ovf_q | b_ovf_q | (|sum_ab[W+1:W]);
        b_ovf_d = a_ovf_q | b_ovf_q | (|sum_a2b[W+1:W]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= W'(1);
            b_q         <= W'(1);
            a_ovf_q     <= 1'b0;
            b_ovf_q     <= 1'b0;
            steps_q     <= '0;
            odd_q       <= 1'b0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_value_q <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        a_q     <= W'(1);
                        b_q     <= W'(1);
                        a_ovf_q <= 1'b0;
                        b_ovf_q <= 1'b0;
                        steps_q <= hs_index[IDXW-1:1];
                        odd_q   <= hs_index[0];
                        id_q    <= hs_port;
                        last_q  <= hs_port;
                        if (hs_index[IDXW-1:1] == '0) begin
                            // F(0) and F(1) are both 1, no iteration needed.
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_value_q <= W'(1);
                            rsp_ovf_q   <= 1'b0;
                            rsp_id_q    <= hs_port;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    a_ovf_q <= a_ovf_d;
                    b_ovf_q <= b_ovf_d;
                    steps_q <= steps_q - 1'b1;
                    if (steps_q == IDXW'(1)) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_value_q <= odd_q ? b_d : a_d;
                        rsp_ovf_q   <= odd_q ? b_ovf_d : a_ovf_d;
                        rsp_id_q    <= id_q;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_value = rsp_value_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fib_req_arbiter.sv
// Scoreboard bench for fib_req_arbiter: expected responses queued at request grant, checked at response handshake.
module tb_fib_req_arbiter;
    localparam int W    = 16;
    localparam int IDXW = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic            req0_valid, req1_valid;
    logic [IDXW-1:0] req0_index, req1_index;
    logic            req0_ready, req1_ready;
    logic            rsp_valid, rsp_ready, rsp_id, rsp_ovf, busy;
    logic [W-1:0]    rsp_value;

    fib_req_arbiter #(.W(W), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_index(req0_index), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_index(req1_index), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_value(rsp_value), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic         id;
        logic [W-1:0] val;
        logic         ovf;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   first_cyc = 0;
    logic pv = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: iterate the sequence in 64 bits, F(63) fits comfortably.
    function automatic exp_t model(input int id, input int n);
        longint unsigned x = 1, y = 1, t;
        exp_t r;
        for (int i = 0; i < n; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        r.id  = id[0];
        r.val = x[W-1:0];
        r.ovf = (x >= (64'd1 << W));
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            pv <= 1'b0;
        end else begin
            if (rsp_valid && !pv) first_cyc <= cyc;
            pv <= rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("rsp_value", rsp_value, mon_e.val);
                    chk("rsp_id", rsp_id, mon_e.id);
                    chk("rsp_ovf", rsp_ovf, mon_e.ovf);
                end
            end
        end
    end

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Drive one request, returns the cycle number of the handshake cycle.
    task automatic issue(input int p, input int n, output int c0);
        logic rdy, other;
        @(posedge clk); #1;
        if (p == 0) begin req0_valid = 1'b1; req0_index = IDXW'(n); end
        else        begin req1_valid = 1'b1; req1_index = IDXW'(n); end
        c0 = -1;
        rdy = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            rdy   = (p == 0) ? req0_ready : req1_ready;
            other = (p == 0) ? req1_ready : req0_ready;
            if (rdy) begin
                c0 = cyc;
                chk("other_ready", other, 0);
                sbq.push_back(model(p, n));
                break;
            end
        end
        if (c0 < 0) chk("grant_timeout", rdy, 1);
        @(posedge clk); #1;
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !busy) begin done = 1'b1; break; end
        end
        if (!done) chk("done_timeout", sbq.size(), 0);
    endtask

    int c0, p, n, exp_port, got_port;
    logic [W-1:0] hv;
    logic hid, hovf;
    bit seen;

    initial begin
        rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_index = '0; req1_index = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_value", rsp_value, 0);
        chk("rst_rsp_ovf", rsp_ovf, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_ready", {req0_ready, req1_ready}, 0);

        issue(0, 0, c0); wait_done();
        chk("lat_n0", first_cyc - c0, 1);

        issue(1, 10, c0);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("busy_n10", busy, (k <= 6));
        end
        wait_done();
        chk("lat_n10", first_cyc - c0, 6);

        issue(0, 23, c0); wait_done();
        chk("lat_n23", first_cyc - c0, 12);
        issue(1, 24, c0); wait_done();
        issue(0, 63, c0); wait_done();
        chk("lat_n63", first_cyc - c0, 32);

        // Both ports valid out of reset: expect 0, 1, 0.
        @(posedge clk); #1;
        rst = 1'b1;
        req0_valid = 1'b1; req0_index = 6'd5;
        req1_valid = 1'b1; req1_index = 6'd6;
        @(negedge clk);
        chk("ready_in_rst", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1 rst = 1'b0;
        for (int g = 0; g < 3; g++) begin
            exp_port = (g == 1) ? 1 : 0;
            seen = 1'b0;
            for (int k = 0; k < 100; k++) begin
                if (req0_ready || req1_ready) begin seen = 1'b1; break; end
                @(negedge clk);
            end
            if (!seen) chk("rr_timeout", req0_ready | req1_ready, 1);
            else begin
                got_port = int'(req1_ready);
                chk("rr_grant", got_port, exp_port);
                chk("rr_onehot", req0_ready & req1_ready, 0);
                sbq.push_back(model(got_port, got_port ? 6 : 5));
                if (g == 2) begin
                    @(posedge clk); #1;
                    req0_valid = 1'b0; req1_valid = 1'b0;
                end else @(negedge clk);
            end
        end
        wait_done();

        // Response stall with a competing request pending.
        rsp_ready = 1'b0;
        issue(0, 7, c0);
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        chk("stall_valid", rsp_valid, 1);
        hv = rsp_value; hid = rsp_id; hovf = rsp_ovf;
        req1_valid = 1'b1; req1_index = 6'd3;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_value", rsp_value, 21);
            chk("stall_id", rsp_id, hid);
            chk("stall_ovf", rsp_ovf, hovf);
            chk("stall_ready", {req0_ready, req1_ready}, 0);
        end
        chk("stall_hold", hv, 21);
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_stall_busy", busy, 0);
        chk("post_stall_grant", req1_ready, 1);
        sbq.push_back(model(1, 3));
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_done();

        // Reset mid-RUN discards the request.
        issue(0, 40, c0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", rsp_valid, 0);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (rsp_valid) chk("midrst_no_rsp", rsp_valid, 0);
        end
        issue(0, 2, c0); wait_done();
        chk("lat_n2", first_cyc - c0, 2);

        // last returns to 1 on reset, so port 0 wins a tie again.
        apply_reset();
        req0_valid = 1'b1; req0_index = 6'd1;
        req1_valid = 1'b1; req1_index = 6'd1;
        @(negedge clk);
        chk("tie_after_rst", {req0_ready, req1_ready}, 2'b10);
        sbq.push_back(model(0, 1));
        @(posedge clk); #1 req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("tie_second", req1_ready, 1);
        sbq.push_back(model(1, 1));
        @(posedge clk); #1 req1_valid = 1'b0;
        wait_done();

        for (int i = 0; i < 10; i++) begin
            p = $urandom_range(0, 1);
            n = $urandom_range(0, 63);
            issue(p, n, c0); wait_done();
            chk("lat_rand", first_cyc - c0, n / 2 + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end
endmodule
